booth_pp_accumulator: RTL and testbench

BOOTH_PP_ACCUMULATOR -- requirements
Module: booth_pp_accumulator

---
 rtl/booth_pp_accumulator.sv | 124 ++++++++++++
 tb/tb_booth_pp_accumulator.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/booth_pp_accumulator.sv
// Sequential accumulator for radix-4 Booth partial-product rows, producing a 32-bit signed product.
// Define BOOTH_ACC_DUAL_ROW_EN to fold two rows per cycle (4-cycle latency instead of 8).
module booth_pp_accumulator #(
  parameter int BITWIDTH = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [BITWIDTH:0]       row0,
  input  logic [BITWIDTH:0]       row1,
  input  logic [BITWIDTH:0]       row2,
  input  logic [BITWIDTH:0]       row3,
  input  logic [BITWIDTH:0]       row4,
  input  logic [BITWIDTH:0]       row5,
  input  logic [BITWIDTH:0]       row6,
  input  logic [BITWIDTH:0]       row7,
  input  logic [7:0]              add,
  output logic [2*BITWIDTH-1:0]   product,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    busy
);

  localparam int ROW_W = BITWIDTH + 1;
  localparam int ACC_W = 2 * BITWIDTH;
  // Cancels the 2^16 bias introduced by the inverted sign bit of every row.
  localparam logic [ACC_W-1:0] SIGN_FIX = 32'hAAAB0000;

  typedef enum logic [1:0] {
    IDLE,
    ACC,
    DONE
  } state_e;

  state_e             state_q, state_d;
  logic [2:0]         cnt_q, cnt_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [7:0]         add_q, add_d;
  logic [ROW_W-1:0]   rows_q [8];
  logic [ROW_W-1:0]   rows_d [8];
  logic [ROW_W-1:0]   row_in [8];
  logic [ACC_W-1:0]   add_vec;

  function automatic logic [ACC_W-1:0] place(input logic [ROW_W-1:0] r, input logic [2:0] idx);
    return {{(ACC_W-ROW_W){1'b0}}, r} << {idx, 1'b0};
  endfunction

  always_comb begin
    row_in[0] = row0;
    row_in[1] = row1;
    row_in[2] = row2;
    row_in[3] = row3;
    row_in[4] = row4;
    row_in[5] = row5;
    row_in[6] = row6;
    row_in[7] = row7;
  end

  always_comb begin
    add_vec = '0;
    for (int j = 0; j < 8; j++) add_vec[2*j] = add[j];
  end

  // NOTE: every next-state signal gets its hold value first, so no path through the case infers a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    add_d   = add_q;
    rows_d  = rows_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          rows_d  = row_in;
          add_d   = add;
          acc_d   = SIGN_FIX + add_vec;
          cnt_d   = 3'd0;
          state_d = ACC;
        end
      end
      ACC: begin
`ifdef BOOTH_ACC_DUAL_ROW_EN
        acc_d = acc_q + place(rows_q[cnt_q], cnt_q)
                      + place(rows_q[cnt_q + 3'd1], cnt_q + 3'd1);
        cnt_d = cnt_q + 3'd2;
        if (cnt_q == 3'd6) state_d = DONE;
`else
        acc_d = acc_q + place(rows_q[cnt_q], cnt_q);
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == 3'd7) state_d = DONE;
`endif
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 3'd0;
      acc_q   <= '0;
      add_q   <= '0;
      // NOTE: the row store is a small register array, so it is cleared explicitly with the rest.
      for (int j = 0; j < 8; j++) rows_q[j] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      add_q   <= add_d;
      rows_q  <= rows_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign product   = acc_q;

endmodule

// File: tb/tb_booth_pp_accumulator.sv
// Directed bench for booth_pp_accumulator; rows come from a radix-4 Booth generator model.
module tb_booth_pp_accumulator;

`ifdef BOOTH_ACC_DUAL_ROW_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 8;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        out_ready;
  logic [16:0] rows_v [8];
  logic [7:0]  add_v;
  logic        in_ready;
  logic        out_valid;
  logic        busy;
  logic [31:0] product;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  booth_pp_accumulator #(.BITWIDTH(16)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .row0     (rows_v[0]),
    .row1     (rows_v[1]),
    .row2     (rows_v[2]),
    .row3     (rows_v[3]),
    .row4     (rows_v[4]),
    .row5     (rows_v[5]),
    .row6     (rows_v[6]),
    .row7     (rows_v[7]),
    .add      (add_v),
    .product  (product),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .busy     (busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Radix-4 Booth rows: 17-bit row with inverted sign bit, negation +1 on add[j].
  task automatic booth_gen(input logic [15:0] x, input logic [15:0] y);
    logic [16:0] ye, xe, mag, v;
    logic [2:0]  trip;
    logic        neg;
    ye = {y, 1'b0};
    xe = {x[15], x};
    for (int j = 0; j < 8; j++) begin
      trip = ye[2*j+2 -: 3];
      case (trip)
        3'b001, 3'b010: begin mag = xe;      neg = 1'b0; end
        3'b011:         begin mag = xe << 1; neg = 1'b0; end
        3'b100:         begin mag = xe << 1; neg = 1'b1; end
        3'b101, 3'b110: begin mag = xe;      neg = 1'b1; end
        default:        begin mag = '0;      neg = 1'b0; end
      endcase
      v = neg ? ~mag : mag;
      rows_v[j] = {~v[16], v[15:0]};
      add_v[j]  = neg;
    end
  endtask

  task automatic run_op(input string tag, input logic [15:0] x, input logic [15:0] y,
                        input logic [31:0] exp, input bit scramble, input int hold);
    int lat;
    int waited;
    booth_gen(x, y);
    waited = 0;
    while (!in_ready && waited < 20) begin
      @(posedge clk); #1;
      waited++;
    end
    check({tag, " ready_before"}, in_ready, 1);
    in_valid = 1'b1;
    @(posedge clk); #1;
    if (scramble) begin
      for (int j = 0; j < 8; j++) rows_v[j] = 17'($urandom);
      add_v = 8'($urandom);
    end else begin
      in_valid = 1'b0;
    end
    check({tag, " busy"}, busy, 1);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    in_valid = 1'b0;
    check({tag, " latency"}, lat, LAT);
    check({tag, " product"}, product, exp);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check({tag, " hold_product"}, product, exp);
      check({tag, " hold_valid"}, out_valid, 1);
      check({tag, " hold_in_ready"}, in_ready, 0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, " valid_drop"}, out_valid, 0);
    check({tag, " ready_after"}, in_ready, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int seen;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    add_v     = '0;
    for (int j = 0; j < 8; j++) rows_v[j] = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst in_ready", in_ready, 1);
    check("rst out_valid", out_valid, 0);
    check("rst busy", busy, 0);
    check("rst product", product, 32'h0);
    rst = 1'b0;

    run_op("3x5", 16'd3, 16'd5, 32'h0000000F, 1'b1, 0);
    run_op("min_sq", 16'h8000, 16'h8000, 32'h40000000, 1'b0, 0);
    run_op("max_min", 16'h7FFF, 16'h8000, 32'hC0008000, 1'b0, 0);
    run_op("zero", 16'h0000, 16'h1234, 32'h00000000, 1'b0, 0);
    run_op("neg1", 16'hFFFF, 16'h0001, 32'hFFFFFFFF, 1'b0, 5);

    // Reset during the third ACC edge aborts the operation.
    booth_gen(16'd100, 16'd200);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort busy", busy, 0);
    check("abort out_valid", out_valid, 0);
    check("abort product", product, 32'h0);
    check("abort in_ready", in_ready, 1);
    seen = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    check("abort never_valid", seen, 0);
    run_op("100x200", 16'd100, 16'd200, 32'h00004E20, 1'b0, 0);

    // Reset wins over a simultaneous acceptance.
    booth_gen(16'd7, 16'd9);
    in_valid = 1'b1;
    rst      = 1'b1;
    @(posedge clk); #1;
    rst      = 1'b0;
    in_valid = 1'b0;
    check("rst_prio busy", busy, 0);
    check("rst_prio product", product, 32'h0);
    run_op("7x9", 16'd7, 16'd9, 32'h0000003F, 1'b0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
